// File: rtl/mips_cpu_avl_master.sv
// Avalon-MM master arbitrating MIPS instruction-fetch and data requests onto one port.
// Optional build macro AVL_MASTER_TIMEOUT_EN adds a waitrequest timeout with a sticky bus_err.
module mips_cpu_avl_master #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_done,
  input  logic        d_read,
  input  logic        d_write,
  input  logic [31:0] d_addr,
  input  logic [3:0]  d_byteenable,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_done,
  output logic        bus_err,
  output logic [31:0] address,
  output logic [3:0]  byteenable,
  output logic [31:0] writedata,
  output logic        read,
  output logic        write,
  input  logic [31:0] readdata,
  input  logic        waitrequest
);

  typedef enum logic [1:0] {IDLE, IBUS, DBUS, DONE} state_e;

  state_e      state_q;
  logic [31:0] address_q, writedata_q, if_rdata_q, d_rdata_q;
  logic [3:0]  byteenable_q;
  logic        read_q, write_q, if_done_q, d_done_q;

`ifdef AVL_MASTER_TIMEOUT_EN
  localparam int CNT_RAW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int CNT_W   = (CNT_RAW < 8) ? 8 : ((CNT_RAW > 32) ? 32 : CNT_RAW);
  // Abort fires on the wait cycle that would bring the count up to TIMEOUT_CYCLES.
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] wait_cnt_q;
  logic             bus_err_q;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      address_q    <= '0;
      byteenable_q <= '0;
      writedata_q  <= '0;
      read_q       <= 1'b0;
      write_q      <= 1'b0;
      if_rdata_q   <= '0;
      d_rdata_q    <= '0;
      if_done_q    <= 1'b0;
      d_done_q     <= 1'b0;
`ifdef AVL_MASTER_TIMEOUT_EN
      wait_cnt_q   <= '0;
      bus_err_q    <= 1'b0;
`endif
    end else begin
      if_done_q <= 1'b0;
      d_done_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (d_read || d_write) begin
            address_q    <= d_addr;
            byteenable_q <= d_byteenable;
            writedata_q  <= d_wdata;
            read_q       <= d_read;
            write_q      <= d_write && !d_read;
            state_q      <= DBUS;
`ifdef AVL_MASTER_TIMEOUT_EN
            wait_cnt_q   <= '0;
`endif
          end else if (if_req) begin
            address_q    <= if_addr;
            byteenable_q <= 4'hF;
            read_q       <= 1'b1;
            write_q      <= 1'b0;
            state_q      <= IBUS;
`ifdef AVL_MASTER_TIMEOUT_EN
            wait_cnt_q   <= '0;
`endif
          end
        end
        IBUS, DBUS: begin
          if (!waitrequest) begin
            if (state_q == IBUS) begin
              if_rdata_q <= readdata;
              if_done_q  <= 1'b1;
            end else begin
              if (read_q) d_rdata_q <= readdata;
              d_done_q <= 1'b1;
            end
            read_q       <= 1'b0;
            write_q      <= 1'b0;
            byteenable_q <= '0;
            state_q      <= DONE;
          end
`ifdef AVL_MASTER_TIMEOUT_EN
          else if (wait_cnt_q == TMO_LAST) begin
            if (state_q == IBUS) begin
              if_rdata_q <= '0;
              if_done_q  <= 1'b1;
            end else begin
              if (read_q) d_rdata_q <= '0;
              d_done_q <= 1'b1;
            end
            read_q       <= 1'b0;
            write_q      <= 1'b0;
            byteenable_q <= '0;
            bus_err_q    <= 1'b1;
            wait_cnt_q   <= wait_cnt_q + 1'b1;
            state_q      <= DONE;
          end else begin
            wait_cnt_q <= wait_cnt_q + 1'b1;
          end
`endif
        end
        // Requests seen here are stale copies of the one just served; ignore them.
        DONE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign address    = address_q;
  assign byteenable = byteenable_q;
  assign writedata  = writedata_q;
  assign read       = read_q;
  assign write      = write_q;
  assign if_rdata   = if_rdata_q;
  assign if_done    = if_done_q;
  assign d_rdata    = d_rdata_q;
  assign d_done     = d_done_q;

`ifdef AVL_MASTER_TIMEOUT_EN
  assign bus_err = bus_err_q;
`else
  assign bus_err = 1'b0;
`endif

endmodule

// File: tb/tb_mips_cpu_avl_master.sv
// Directed bench for mips_cpu_avl_master; covers timeout behaviour when AVL_MASTER_TIMEOUT_EN is defined.
module tb_mips_cpu_avl_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_done;
  logic        d_read, d_write;
  logic [31:0] d_addr;
  logic [3:0]  d_byteenable;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_done;
  logic        bus_err;
  logic [31:0] address;
  logic [3:0]  byteenable;
  logic [31:0] writedata;
  logic        read, write;
  logic [31:0] readdata;
  logic        waitrequest;

  int n_checks = 0;
  int n_fail   = 0;

  mips_cpu_avl_master #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_byteenable(d_byteenable),
    .d_wdata(d_wdata), .d_rdata(d_rdata), .d_done(d_done), .bus_err(bus_err),
    .address(address), .byteenable(byteenable), .writedata(writedata),
    .read(read), .write(write), .readdata(readdata), .waitrequest(waitrequest)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    tick(); tick();
    @(negedge clk);
    rst = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    if_req = 0; if_addr = '0; d_read = 0; d_write = 0; d_addr = '0;
    d_byteenable = '0; d_wdata = '0; readdata = '0; waitrequest = 0;
    apply_reset();
    n_checks++; if ({read, write} !== 2'b00) begin n_fail++; $display("FAIL reset_rw got %b want 00", {read, write}); end
    n_checks++; if (address !== 32'h0 || byteenable !== 4'h0 || writedata !== 32'h0) begin n_fail++; $display("FAIL reset_cmd got %h/%h/%h want 0", address, byteenable, writedata); end
    n_checks++; if (if_rdata !== 32'h0 || d_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata got %h/%h want 0", if_rdata, d_rdata); end
    n_checks++; if ({if_done, d_done, bus_err} !== 3'b000) begin n_fail++; $display("FAIL reset_flags got %b want 000", {if_done, d_done, bus_err}); end
  endtask

  task automatic test_fetch();
    if_req = 1; if_addr = 32'hBFC00000; waitrequest = 1; readdata = 32'h3C011234;
    for (int i = 1; i <= 3; i++) begin
      tick();
      n_checks++; if (read !== 1'b1 || write !== 1'b0 || address !== 32'hBFC00000 || byteenable !== 4'hF) begin n_fail++; $display("FAIL fetch_hold%0d got r%b w%b %h %h want r1 w0 bfc00000 f", i, read, write, address, byteenable); end
      n_checks++; if (if_done !== 1'b0) begin n_fail++; $display("FAIL fetch_early_done%0d got %b want 0", i, if_done); end
    end
    waitrequest = 0;
    tick();
    n_checks++; if (if_done !== 1'b1 || if_rdata !== 32'h3C011234) begin n_fail++; $display("FAIL fetch_done got %b %h want 1 3c011234", if_done, if_rdata); end
    n_checks++; if (read !== 1'b0 || byteenable !== 4'h0) begin n_fail++; $display("FAIL fetch_release got r%b be%h want r0 be0", read, byteenable); end
    if_req = 0;
    tick();
    n_checks++; if (if_done !== 1'b0 || if_rdata !== 32'h3C011234) begin n_fail++; $display("FAIL fetch_pulse_end got %b %h want 0 3c011234", if_done, if_rdata); end
    tick();
  endtask

  task automatic test_data_read();
    d_read = 1; d_addr = 32'h00000080; d_byteenable = 4'hF; waitrequest = 0; readdata = 32'h12345678;
    tick();
    n_checks++; if (read !== 1'b1 || address !== 32'h80) begin n_fail++; $display("FAIL dread_cmd got r%b %h want r1 80", read, address); end
    tick();
    n_checks++; if (d_done !== 1'b1 || d_rdata !== 32'h12345678 || if_done !== 1'b0) begin n_fail++; $display("FAIL dread_done got %b %h ifd%b want 1 12345678 0", d_done, d_rdata, if_done); end
    d_read = 0;
    tick(); tick();
  endtask

  task automatic test_write();
    d_write = 1; d_addr = 32'h00000010; d_byteenable = 4'b0011; d_wdata = 32'hCAFEBABE;
    waitrequest = 0; readdata = 32'hDEADDEAD;
    tick();
    n_checks++; if (write !== 1'b1 || read !== 1'b0) begin n_fail++; $display("FAIL write_rw got w%b r%b want w1 r0", write, read); end
    n_checks++; if (address !== 32'h10 || byteenable !== 4'b0011 || writedata !== 32'hCAFEBABE) begin n_fail++; $display("FAIL write_cmd got %h %h %h want 10 3 cafebabe", address, byteenable, writedata); end
    tick();
    n_checks++; if (write !== 1'b0 || d_done !== 1'b1) begin n_fail++; $display("FAIL write_done got w%b d%b want w0 d1", write, d_done); end
    n_checks++; if (d_rdata !== 32'h12345678) begin n_fail++; $display("FAIL write_rdata got %h want 12345678", d_rdata); end
    d_write = 0;
    tick();
    n_checks++; if (d_done !== 1'b0) begin n_fail++; $display("FAIL write_pulse_end got %b want 0", d_done); end
    tick();
  endtask

  task automatic test_priority();
    if_req = 1; if_addr = 32'h00000100; d_read = 1; d_addr = 32'h00000020; d_byteenable = 4'hF;
    waitrequest = 0; readdata = 32'hAAAA0001;
    tick();
    n_checks++; if (read !== 1'b1 || address !== 32'h20) begin n_fail++; $display("FAIL prio_first got r%b %h want r1 20", read, address); end
    tick();
    n_checks++; if (d_done !== 1'b1 || if_done !== 1'b0 || d_rdata !== 32'hAAAA0001) begin n_fail++; $display("FAIL prio_ddone got d%b i%b %h want d1 i0 aaaa0001", d_done, if_done, d_rdata); end
    d_read = 0; readdata = 32'hBBBB0002;
    tick();
    n_checks++; if (read !== 1'b0 || d_done !== 1'b0 || if_done !== 1'b0) begin n_fail++; $display("FAIL prio_gap got r%b d%b i%b want 000", read, d_done, if_done); end
    tick();
    n_checks++; if (read !== 1'b1 || address !== 32'h100 || byteenable !== 4'hF) begin n_fail++; $display("FAIL prio_fetch got r%b %h %h want r1 100 f", read, address, byteenable); end
    tick();
    n_checks++; if (if_done !== 1'b1 || d_done !== 1'b0 || if_rdata !== 32'hBBBB0002 || d_rdata !== 32'hAAAA0001) begin n_fail++; $display("FAIL prio_idone got i%b d%b %h %h want i1 d0 bbbb0002 aaaa0001", if_done, d_done, if_rdata, d_rdata); end
    if_req = 0;
    tick();
    n_checks++; if (if_done !== 1'b0) begin n_fail++; $display("FAIL prio_pulse_end got %b want 0", if_done); end
    tick();
  endtask

  task automatic test_hold_through_done();
    int reads = 0;
    int dones = 0;
    d_read = 1; d_addr = 32'h00000040; d_byteenable = 4'hF; waitrequest = 0; readdata = 32'h00000055;
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (read === 1'b1) reads++;
      if (d_done === 1'b1) dones++;
      if (i == 3) d_read = 0;
    end
    n_checks++; if (reads !== 1) begin n_fail++; $display("FAIL hold_reads got %0d want 1", reads); end
    n_checks++; if (dones !== 1 || d_rdata !== 32'h55) begin n_fail++; $display("FAIL hold_dones got %0d %h want 1 55", dones, d_rdata); end
  endtask

  task automatic test_reset_mid();
    d_read = 1; d_addr = 32'h00000044; d_byteenable = 4'hF; waitrequest = 1;
    tick();
    n_checks++; if (read !== 1'b1) begin n_fail++; $display("FAIL rstmid_pre got %b want 1", read); end
    #2 rst = 1'b0;
    #1;
    n_checks++; if (read !== 1'b0 || byteenable !== 4'h0 || address !== 32'h0) begin n_fail++; $display("FAIL rstmid_async got r%b %h %h want r0 0 0", read, byteenable, address); end
    d_read = 0; waitrequest = 0;
    @(negedge clk);
    rst = 1'b1;
    tick();
    n_checks++; if (read !== 1'b0 || d_done !== 1'b0) begin n_fail++; $display("FAIL rstmid_after got r%b d%b want 00", read, d_done); end
    if_req = 1; if_addr = 32'h00000200; readdata = 32'h01020304;
    tick();
    n_checks++; if (read !== 1'b1 || address !== 32'h200) begin n_fail++; $display("FAIL rstmid_idle got r%b %h want r1 200", read, address); end
    tick();
    n_checks++; if (if_done !== 1'b1 || if_rdata !== 32'h01020304) begin n_fail++; $display("FAIL rstmid_fetch got %b %h want 1 01020304", if_done, if_rdata); end
    if_req = 0;
    tick(); tick();
  endtask

`ifdef AVL_MASTER_TIMEOUT_EN
  task automatic test_timeout();
    d_read = 1; d_addr = 32'h00000060; d_byteenable = 4'hF; waitrequest = 1; readdata = 32'hFFFFFFFF;
    for (int i = 1; i <= 4; i++) begin
      tick();
      n_checks++; if (read !== 1'b1 || bus_err !== 1'b0 || d_done !== 1'b0) begin n_fail++; $display("FAIL tmo_wait%0d got r%b e%b d%b want r1 e0 d0", i, read, bus_err, d_done); end
    end
    tick();
    n_checks++; if (read !== 1'b0 || bus_err !== 1'b1 || d_done !== 1'b1 || d_rdata !== 32'h0) begin n_fail++; $display("FAIL tmo_abort got r%b e%b d%b %h want r0 e1 d1 0", read, bus_err, d_done, d_rdata); end
    d_read = 0;
    tick();
    n_checks++; if (d_done !== 1'b0 || bus_err !== 1'b1) begin n_fail++; $display("FAIL tmo_after got d%b e%b want d0 e1", d_done, bus_err); end
    tick();
    d_read = 1; waitrequest = 0; readdata = 32'h00000077;
    tick(); tick();
    n_checks++; if (d_done !== 1'b1 || d_rdata !== 32'h77 || bus_err !== 1'b1) begin n_fail++; $display("FAIL tmo_sticky got d%b %h e%b want d1 77 e1", d_done, d_rdata, bus_err); end
    d_read = 0;
    tick();
    apply_reset();
    n_checks++; if (bus_err !== 1'b0) begin n_fail++; $display("FAIL tmo_clear got %b want 0", bus_err); end
  endtask
`else
  task automatic test_timeout();
    d_read = 1; d_addr = 32'h00000060; d_byteenable = 4'hF; waitrequest = 1; readdata = 32'h00000066;
    for (int i = 1; i <= 10; i++) tick();
    n_checks++; if (read !== 1'b1 || bus_err !== 1'b0 || d_done !== 1'b0) begin n_fail++; $display("FAIL nowait_hold got r%b e%b d%b want r1 e0 d0", read, bus_err, d_done); end
    waitrequest = 0;
    tick();
    n_checks++; if (d_done !== 1'b1 || d_rdata !== 32'h66 || bus_err !== 1'b0) begin n_fail++; $display("FAIL nowait_done got d%b %h e%b want d1 66 e0", d_done, d_rdata, bus_err); end
    d_read = 0;
    tick(); tick();
  endtask
`endif

  initial begin
    rst = 1'b0;
    test_reset();
    test_fetch();
    test_data_read();
    test_write();
    test_priority();
    test_hold_through_done();
    test_reset_mid();
    test_timeout();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mips_cpu_avl_master.md
# mips_cpu_avl_master

Avalon-MM bus master for the MIPS CPU. It accepts instruction-fetch and data-access requests from the core, arbitrates between them, and drives a single Avalon-MM port toward the memory slave, holding all command signals stable while `waitrequest` is high. Returned read data goes back to the requesting side with a one-cycle done pulse. It sits between the core's fetch/memory stages and the system memory.

## Interface
- `TIMEOUT_CYCLES`, 255: maximum cycles a command is held against `waitrequest` before abort (used only with the timeout feature).
- `clk` in 1: system clock, all logic on rising edge.
- `rst` in 1: reset, asynchronous, active-low (asserted when 0).
- `if_req` in 1: instruction fetch request, held until `if_done`.
- `if_addr` in 32: fetch byte address, word-aligned.
- `if_rdata` out 32: fetched word; valid with `if_done`, held until the next fetch completes.
- `if_done` out 1: one-cycle fetch completion pulse.
- `d_read` / `d_write` in 1 each: data request; never both 1. Held until `d_done`.
- `d_addr` in 32: data byte address, word-aligned.
- `d_byteenable` in 4: lane enables.
- `d_wdata` in 32: write data.
- `d_rdata` out 32: read data; valid with `d_done`, held until the next data read completes.
- `d_done` out 1: one-cycle data completion pulse, for both reads and writes.
- `bus_err` out 1: sticky abort flag (timeout build only, else constant 0).
- `address` out 32, `byteenable` out 4, `writedata` out 32, `read` out 1, `write` out 1: Avalon command, all registered.
- `readdata` in 32, `waitrequest` in 1: Avalon response.

## Operation
- FSM states: IDLE, IBUS, DBUS, DONE.
- IDLE:
  - If `d_read` or `d_write` is set, latch the data command and go to DBUS.
  - Otherwise, if `if_req` is set, latch `if_addr` with `byteenable`=4'hF, `read`=1, and go to IBUS.
  - Data has priority over fetch when both arrive in the same cycle.
- IBUS/DBUS: hold `address`, `byteenable`, `writedata`, `read` and `write` unchanged while `waitrequest`=1. On a cycle with `waitrequest`=0:
  - Read: capture `readdata` into `if_rdata` or `d_rdata`.
  - Both cases: deassert `read`/`write`, zero `byteenable`, pulse the matching done, go to DONE.
- DONE: lasts one cycle; requests are ignored in this cycle so a requester dropping its request is not reissued. Then go to IDLE.
- `read` and `write` are never 1 together.
- `address` is passed through unmodified; the slave decodes instruction vs data space.
- A data write does not alter `d_rdata`.
- A fetch pending behind a data access is served on the first IDLE after that access's DONE.

## Timing
- Reset values: all Avalon outputs 0, `if_rdata`/`d_rdata` 0, `if_done`/`d_done` 0, `bus_err` 0, state IDLE.
- Reset assertion mid-transaction clears `read`/`write` immediately (asynchronously) and drops the transaction. No done pulse is generated.
- Request-to-command latency: 1 cycle. Request sampled at edge N; `read`/`write` high from edge N.
- Completion: if `waitrequest` is low in cycle M, done is high in cycle M+1 and `read`/`write` are low from M+1.
- With zero waitrequest, total request-to-done is 2 cycles. Minimum spacing between two bus commands is 2 idle cycles (DONE, IDLE).
- Against the team's three-state memory slave (waitrequest high for 2 cycles), a read takes 4 cycles from request to done.

## Configuration
- `AVL_MASTER_TIMEOUT_EN` defined:
  - An 8..32-bit counter increments each IBUS/DBUS cycle in which `waitrequest`=1 and clears on entry to IBUS/DBUS.
  - When the counter reaches `TIMEOUT_CYCLES`, deassert `read`/`write`, set `bus_err`=1 (sticky until reset), pulse the pending done with rdata forced to 32'h0, and go to DONE.
- `AVL_MASTER_TIMEOUT_EN` undefined: no counter; `bus_err` tied 0; waits indefinitely.

## Test plan
- Fetch, `if_addr`=32'hBFC00000, slave holds `waitrequest` 2 cycles then returns 32'h3C011234 -> `address`/`read` stable throughout; `if_rdata`=32'h3C011234 with `if_done` high exactly 1 cycle, 4 cycles after request.
- Write, `d_addr`=32'h00000010, `d_byteenable`=4'b0011, `d_wdata`=32'hCAFEBABE, zero wait -> one `write` cycle with those values; `d_done` the next cycle; `d_rdata` unchanged.
- `if_req` and `d_read` asserted together -> data transaction issued first; fetch issued after DONE; each done pulses once.
- `rst` driven low while `read`=1 and `waitrequest`=1 -> `read` drops to 0 without a clock edge; no done pulse; IDLE after release.
- Requester holds `d_read` through the `d_done` cycle then drops it -> exactly one bus read issued.
- Timeout build, `TIMEOUT_CYCLES`=4, `waitrequest` stuck at 1 -> `read` drops after 4 wait cycles; `bus_err`=1; `d_done` with `d_rdata`=0; `bus_err` stays 1 until reset.
